// File: rtl/spi_adc_reader.sv
// spi_adc_reader: parametrised SPI ADC reader with pipelined channel addressing.
// Optional macro SPI_ADC_CMP_EN adds thresh input and registered out_above flag.
module spi_adc_reader #(
    parameter int DATA_W     = 8,
    parameter int LEAD_BITS  = 3,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 1,
    parameter int GAP_CYC    = 1,
    parameter int NUM_CH     = 1,
    parameter int ADDR_POS   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic              adc_cs,
    output logic              adc_clk,
    output logic              adc_din,
    input  logic              adc_dat,
`ifdef SPI_ADC_CMP_EN
    input  logic [DATA_W-1:0] thresh,
    output logic              out_above,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_ch
);

    localparam int CMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] DIV_V    = CW'(CLK_DIV);
    localparam logic [CW-1:0] GAP_V    = CW'(GAP_CYC);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] D_FIRST  = BW'(LEAD_BITS);
    localparam logic [BW-1:0] D_LAST   = BW'(LEAD_BITS + DATA_W - 1);
    localparam logic [BW-1:0] A0       = BW'(ADDR_POS);
    localparam logic [BW-1:0] A1       = BW'(ADDR_POS + 1);
    localparam logic [BW-1:0] A2       = BW'(ADDR_POS + 2);
    localparam logic [2:0]    LAST_CH  = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        next_addr;
    logic [2:0]        prev_addr;
    logic [BW-1:0]     nxt_idx;
    logic              in_data;
    logic [2:0]        adv_addr;

    assign nxt_idx  = bit_idx + 1'b1;
    assign in_data  = (bit_idx >= D_FIRST) && (bit_idx <= D_LAST);
    assign adv_addr = (next_addr == LAST_CH) ? 3'd0 : next_addr + 3'd1;

    function automatic logic addr_bit(input logic [BW-1:0] k,
                                      input logic [2:0]    a);
        logic b;
        b = 1'b0;
        unique case (1'b1)
            (k == A0): b = a[2];
            (k == A1): b = a[1];
            (k == A2): b = a[0];
            default:   b = 1'b0;
        endcase
        return b;
    endfunction

    // Frame sequencer: CS/SCLK/DIN generation, capture and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            next_addr <= 3'd0;
            prev_addr <= 3'd0;
            busy      <= 1'b0;
            adc_cs    <= 1'b1;
            adc_clk   <= 1'b1;
            adc_din   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= 3'd0;
`ifdef SPI_ADC_CMP_EN
            out_above <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start || cont) begin
                        state <= SETUP;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SETUP: begin
                    adc_cs <= 1'b0;
                    if (cnt == DIV_V) begin
                        state   <= SHIFT;
                        adc_clk <= 1'b0;
                        bit_idx <= '0;
                        adc_din <= addr_bit('0, next_addr);
                        cnt     <= CW'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!adc_clk) begin
                        if (cnt == DIV_V) begin
                            adc_clk <= 1'b1;
                            cnt     <= CW'(1);
                            if (in_data)
                                shreg <= {shreg[DATA_W-2:0], adc_dat};
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (bit_idx == LAST_BIT) begin
                        state     <= HOLD;
                        adc_cs    <= 1'b1;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= shreg;
                        out_ch    <= prev_addr;
                        prev_addr <= next_addr;
                        next_addr <= adv_addr;
`ifdef SPI_ADC_CMP_EN
                        out_above <= (shreg >= thresh);
`endif
                    end else if (cnt == DIV_V) begin
                        adc_clk <= 1'b0;
                        bit_idx <= nxt_idx;
                        adc_din <= addr_bit(nxt_idx, next_addr);
                        cnt     <= CW'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state <= GAP;
                    cnt   <= CW'(1);
                end
                GAP: begin
                    if (cnt >= GAP_V) begin
                        if (cont) begin
                            state <= SETUP;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_adc_reader.sv
// tb_spi_adc_reader: directed and randomised checks of spi_adc_reader
// against an ADC slave model and frame-level expectations.
module tb_spi_adc_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // instance A: default framing, 4 channels
    logic       a_start = 1'b0, a_cont = 1'b0, a_dat = 1'b0;
    logic       a_busy, a_cs, a_sclk, a_din, a_valid;
    logic [7:0] a_data;
    logic [2:0] a_ch;
`ifdef SPI_ADC_CMP_EN
    logic [7:0] a_thr = 8'h80;
    logic       a_above;
`endif

    // instance C: slow SCLK, 12-bit result
    logic        c_start = 1'b0, c_cont = 1'b0, c_dat = 1'b0;
    logic        c_busy, c_cs, c_sclk, c_din, c_valid;
    logic [11:0] c_data;
    logic [2:0]  c_ch;
`ifdef SPI_ADC_CMP_EN
    logic [11:0] c_thr = 12'h0;
    logic        c_above;
`endif

    spi_adc_reader #(.NUM_CH(4)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (a_start),
        .cont     (a_cont),
        .busy     (a_busy),
        .adc_cs   (a_cs),
        .adc_clk  (a_sclk),
        .adc_din  (a_din),
        .adc_dat  (a_dat),
`ifdef SPI_ADC_CMP_EN
        .thresh   (a_thr),
        .out_above(a_above),
`endif
        .out_valid(a_valid),
        .out_data (a_data),
        .out_ch   (a_ch)
    );

    spi_adc_reader #(
        .DATA_W    (12),
        .LEAD_BITS (4),
        .FRAME_BITS(16),
        .CLK_DIV   (3)
    ) dut_c (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (c_start),
        .cont     (c_cont),
        .busy     (c_busy),
        .adc_cs   (c_cs),
        .adc_clk  (c_sclk),
        .adc_din  (c_din),
        .adc_dat  (c_dat),
`ifdef SPI_ADC_CMP_EN
        .thresh   (c_thr),
        .out_above(c_above),
`endif
        .out_valid(c_valid),
        .out_data (c_data),
        .out_ch   (c_ch)
    );

    typedef struct {
        int         t;
        logic [7:0] d;
        logic [2:0] ch;
        logic       ab;
    } av_t;

    typedef struct {
        int          nf;
        logic [15:0] rx;
    } af_t;

    av_t a_vq[$];
    af_t a_fq[$];
    int  a_csf[$];
    int  c_tq[$];
    int  c_vcnt = 0;
    logic a_pcs = 1'b1;
    logic c_psclk = 1'b1;

    // ADC slave model for A: data field at frame bits 3..10, random elsewhere
    logic [15:0] a_word = 16'h0;
    logic [15:0] a_rx = 16'h0;
    logic [15:0] a_force_word = 16'h0;
    logic        a_force_en = 1'b0;
    logic        a_mode = 1'b0;
    logic [7:0]  a_data_next = 8'h0;
    logic [7:0]  a_dv;
    logic [2:0]  a_prev_addr = 3'd0;
    int          a_fall = 0;

    always @(negedge a_cs) begin
        a_fall = 0;
        a_rx   = 16'h0;
        a_dv   = a_mode ? 8'h10 + {5'd0, a_prev_addr} : a_data_next;
        a_word = 16'($urandom);
        a_word[12:5] = a_dv;
        if (a_force_en) a_word = a_force_word;
        a_dat = a_word[15];
    end

    always @(negedge a_sclk) begin
        if (!a_cs) begin
            if (a_fall < 16) a_dat = a_word[4'(15 - a_fall)];
            a_fall++;
        end
    end

    always @(posedge a_sclk) begin
        if (!a_cs) a_rx = {a_rx[14:0], a_din};
    end

    always @(posedge a_cs) begin
        if (rst_n === 1'b1) begin
            a_fq.push_back('{a_fall, a_rx});
            a_prev_addr = a_rx[13:11];
        end
    end

    always @(negedge rst_n) a_prev_addr = 3'd0;

    always @(negedge clk) begin
        logic ab;
        ab = 1'b0;
`ifdef SPI_ADC_CMP_EN
        ab = a_above;
`endif
        if (a_valid) a_vq.push_back('{cyc, a_data, a_ch, ab});
        if (a_pcs && !a_cs) a_csf.push_back(cyc);
        a_pcs = a_cs;
    end

    always @(negedge clk) begin
        if (c_valid) c_vcnt++;
        if (!c_cs && c_sclk !== c_psclk) c_tq.push_back(cyc);
        c_psclk = c_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic a_oneshot(input int k, input logic [7:0] d,
                             input int repulse, input logic [7:0] thr);
        int t;
        logic [2:0] ech;
        a_vq.delete();
        a_fq.delete();
        a_csf.delete();
        a_data_next = d;
`ifdef SPI_ADC_CMP_EN
        a_thr = thr;
`endif
        ech = (k == 0) ? 3'd0 : 3'((k - 1) % 4);
        a_start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        a_start = 1'b0;
        go_to(t + 1);
        chk("a_cs_low", a_cs, 0);
        chk("a_busy_hi", a_busy, 1);
        if (repulse > 0) begin
            go_to(t + repulse - 1);
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
        end
        go_to(t + 33);
        chk("a_busy_pre", a_busy, 1);
        chk("a_valid_pre", a_valid, 0);
        go_to(t + 34);
        chk("a_valid", a_valid, 1);
        chk("a_busy_end", a_busy, 0);
        chk("a_cs_end", a_cs, 1);
        chk("a_data", a_data, d);
        chk("a_ch", a_ch, ech);
`ifdef SPI_ADC_CMP_EN
        chk("a_above", a_above, (d >= thr) ? 1 : 0);
`endif
        go_to(t + 60);
        chk("a_nvalid", a_vq.size(), 1);
        chk("a_nframes", a_csf.size(), 1);
        chk("a_nrec", a_fq.size(), 1);
        if (a_fq.size() > 0) begin
            chk("a_nfall", a_fq[0].nf, 16);
            chk("a_din_addr", a_fq[0].rx[13:11], 3'(k % 4));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int bad;
        int n0;
        logic [7:0] d;
        logic [7:0] thr;
        logic [2:0] ech;

        repeat (3) @(negedge clk);
        chk("rst_cs", a_cs, 1);
        chk("rst_sclk", a_sclk, 1);
        chk("rst_din", a_din, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 0);
        chk("rst_ch", a_ch, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed pattern 0,0,0,1,0,1,1,0,1,0,...
        a_force_en   = 1'b1;
        a_force_word = 16'h1680;
        a_oneshot(0, 8'hB4, 0, 8'h80);
        a_force_en   = 1'b0;

        // start re-pulsed mid-frame must be ignored
        a_oneshot(1, 8'($urandom), 10, 8'h80);

        for (int k = 2; k < 6; k++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            d   = 8'($urandom);
            thr = 8'($urandom);
            if (k == 2) begin d = 8'h80; thr = 8'h80; end
            if (k == 3) begin d = 8'h7F; thr = 8'h80; end
            a_oneshot(k, d, 0, thr);
        end

        // mid-frame reset
        a_vq.delete();
        a_start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        a_start = 1'b0;
        go_to(t + 16);
        chk("mid_sclk_low", a_sclk, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", a_cs, 1);
        chk("abort_sclk", a_sclk, 1);
        chk("abort_din", a_din, 0);
        chk("abort_busy", a_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        go_to(t + 60);
        chk("abort_novalid", a_vq.size(), 0);
        a_oneshot(0, 8'($urandom), 0, 8'($urandom));

        // continuous scan from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_mode = 1'b1;
        a_vq.delete();
        a_fq.delete();
        a_csf.delete();
        a_cont = 1'b1;
        t = cyc + 1;
        go_to(t + 34 + 36 * 5 + 10);
        a_cont = 1'b0;
        go_to(t + 34 + 36 * 6 + 40);
        chk("cont_nvalid", a_vq.size(), 7);
        chk("cont_nframes", a_csf.size(), 7);
        chk("cont_nrec", a_fq.size(), 7);
        for (int j = 0; j < a_vq.size(); j++) begin
            ech = (j == 0) ? 3'd0 : 3'((j - 1) % 4);
            chk("cont_t", a_vq[j].t, t + 34 + 36 * j);
            chk("cont_ch", a_vq[j].ch, ech);
            chk("cont_data", a_vq[j].d, 8'h10 + {5'd0, ech});
        end
        for (int j = 0; j < a_fq.size(); j++)
            chk("cont_din_addr", a_fq[j].rx[13:11], 3'(j % 4));
        a_mode = 1'b0;

        // slow SCLK, 12-bit capture, all ones then all zeros
        for (int r = 0; r < 2; r++) begin
            c_dat = (r == 0);
            n0 = c_vcnt;
            c_tq.delete();
            @(negedge clk);
            c_start = 1'b1;
            t = cyc + 1;
            @(negedge clk);
            c_start = 1'b0;
            go_to(t + 1);
            chk("c_cs_low", c_cs, 0);
            go_to(t + 97);
            chk("c_valid_pre", c_valid, 0);
            go_to(t + 98);
            chk("c_valid", c_valid, 1);
            chk("c_data", c_data, (r == 0) ? 12'hFFF : 12'h000);
            chk("c_ch", c_ch, 0);
            chk("c_busy_end", c_busy, 0);
            go_to(t + 120);
            chk("c_nvalid", c_vcnt - n0, 1);
            chk("c_ntoggle", c_tq.size(), 32);
            bad = 0;
            for (int i = 1; i < c_tq.size(); i++)
                if (c_tq[i] - c_tq[i-1] != 3) bad++;
            chk("c_phase", bad, 0);
            if (c_tq.size() > 0) chk("c_first_fall", c_tq[0], t + 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
